// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg
// Shared definitions for the 7-segment scan controller:
//   state_t     - scan FSM states (BLANK dead-time slot, SHOW lit slot)
//   SEG_BLANK   - all segments off (active-low)
//   seg_decode  - BCD nibble to active-low {g,f,e,d,c,b,a}; A-F decode to blank
package seg_scan_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] pat;
    case (nibble)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_tick_gen.sv
// seg_tick_gen
// Free-running scan-rate divider. Counts 0..DIV-1 and asserts tick for the
// single cycle in which the count equals DIV-1, then wraps to 0.
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset (count cleared to 0)
//   tick   out  one-cycle pulse every DIV cycles
module seg_tick_gen #(
  parameter int unsigned DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned     CW       = $clog2(DIV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan controller for DIGITS common-anode 7-segment digits
// on a shared segment bus. Each digit gets one blank tick (anti-ghosting)
// followed by SHOW_TICKS lit ticks. New value/dp_mask are taken only at the
// frame-end cycle through load_valid/load_ready, so a frame is never torn.
// Optional build macro:
//   SEG_SCAN_LZB_EN - leading-zero blanking (a lit dp stops blanking for
//                     that digit and all lower digits; digit 0 never blanks)
// Ports:
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   load_valid  in   value/dp_mask offered
//   load_ready  out  high only in the frame-end cycle
//   value       in   BCD nibbles, digit i = value[4i+3:4i], digit 0 rightmost
//   dp_mask     in   decimal point per digit, 1 = lit
//   an          out  anode enables, active-low, at most one low
//   seg         out  segments {g,f,e,d,c,b,a}, active-low
//   dp          out  decimal point, active-low
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned DIV        = 1000,
  parameter int unsigned SHOW_TICKS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int unsigned   IW        = $clog2(DIGITS);
  localparam int unsigned   SW        = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS) : 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [SW-1:0] SHOW_LAST = SW'(SHOW_TICKS - 1);

  logic                 w_tick;
  logic                 w_show_done;
  logic [3:0]           w_nib;
  logic                 w_dp_sel;
  logic                 w_lzb_sel;

  state_t               r_state;
  logic [IW-1:0]        r_idx;
  logic [SW-1:0]        r_show_cnt;
  logic [4*DIGITS-1:0]  r_value;
  logic [DIGITS-1:0]    r_dp_mask;
  logic [DIGITS-1:0]    r_an;
  logic [6:0]           r_seg;
  logic                 r_dp;

  seg_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  // Last tick of the current SHOW slot; on the top digit this is frame end.
  assign w_show_done = w_tick && (r_state == SHOW) && (r_show_cnt == SHOW_LAST);
  assign load_ready  = w_show_done && (r_idx == IDX_LAST);

  // Per-digit selection of nibble, dp and blanking flag for the active index.
`ifdef SEG_SCAN_LZB_EN
  logic [DIGITS-1:0] w_lzb;
  logic              w_run;

  // Walk from the most significant digit down; the run of blanking survives
  // only while every digit seen so far is zero with its dp off.
  always_comb begin
    w_run = 1'b1;
    w_lzb = '0;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      w_run = w_run & (r_value[4*(DIGITS-1-j) +: 4] == 4'd0)
                    & ~r_dp_mask[DIGITS-1-j];
      w_lzb[DIGITS-1-j] = w_run & (j != DIGITS - 1);
    end
  end
`else
  logic [DIGITS-1:0] w_lzb;
  assign w_lzb = '0;
`endif

  always_comb begin
    w_nib     = '0;
    w_dp_sel  = 1'b0;
    w_lzb_sel = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib     = r_value[4*i +: 4];
        w_dp_sel  = r_dp_mask[i];
        w_lzb_sel = w_lzb[i];
      end
    end
  end

  // Scan FSM, digit index and shadow registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= BLANK;
      r_idx      <= '0;
      r_show_cnt <= '0;
      r_value    <= '0;
      r_dp_mask  <= '0;
    end else begin
      if (load_ready && load_valid) begin
        r_value   <= value;
        r_dp_mask <= dp_mask;
      end
      if (w_tick) begin
        case (r_state)
          BLANK: begin
            r_state    <= SHOW;
            r_show_cnt <= '0;
          end
          SHOW: begin
            if (r_show_cnt == SHOW_LAST) begin
              r_state    <= BLANK;
              r_show_cnt <= '0;
              r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
            end else begin
              r_show_cnt <= r_show_cnt + SW'(1);
            end
          end
          default: begin
            r_state    <= BLANK;
            r_show_cnt <= '0;
          end
        endcase
      end
    end
  end

  // Output registers: follow the FSM one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else if (r_state == SHOW) begin
      r_an  <= ~(DIGITS'(1) << r_idx);
      r_seg <= w_lzb_sel ? SEG_BLANK : seg_decode(w_nib);
      r_dp  <= ~w_dp_sel;
    end else begin
      r_an  <= '1;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule
